// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Responder end of the strobe/ack register bus. Captures one transfer per
//   strb, waits WAIT_CYCLES cycles, commits the write or loads read data,
//   then pulses ack for one cycle. Backs a 2**ADDR_W x DATA_W register array.
//   Addresses at or above RO_BASE are read-only: writes there are acked and
//   discarded.
//
// Ports
//   clk    in   1       clock, all logic on posedge
//   rst    in   1       synchronous reset, active-low
//   strb   in   1       transfer request, held until ack is sampled
//   we     in   1       1 = write, 0 = read
//   addr   in   ADDR_W  transfer address
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  registered read data, valid with ack on reads
//   ack    out  1       registered one-cycle completion pulse
//
// state   | meaning
// S_IDLE  | waiting for strb, fields latched on capture
// S_WAIT  | counting wait states down to zero
// S_ACK   | ack high for this single cycle
// S_RELEASE | waiting for the initiator to drop strb
module bus_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RO_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strb,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              enter_ack;
    logic              mem_wr;
    logic              rd_ld;

    logic [DATA_W-1:0] mem [DEPTH];

    // State register plus the per-transfer registers it sequences.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ack   <= enter_ack;
            if (state == S_IDLE && strb) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (rd_ld) begin
                rdata <= mem[cur_addr];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (strb) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = S_ACK;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_ACK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                if (!strb) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // With zero wait states the commit happens on the capture edge itself,
    // so the live bus fields are used instead of the not-yet-latched copies.
    always_comb begin
        cur_we    = (state == S_IDLE) ? we    : we_q;
        cur_addr  = (state == S_IDLE) ? addr  : addr_q;
        cur_wdata = (state == S_IDLE) ? wdata : wdata_q;
        enter_ack = (state_nx == S_ACK) && (state != S_ACK);
        mem_wr    = enter_ack && cur_we && (cur_addr < RO_BASE);
        rd_ld     = enter_ack && !cur_we;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_wr) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

endmodule
